pin_vector_tester: RTL and testbench
====================================

# pin_vector_tester

Exhaustive pin-level tester for the inverted-first-input OR function mapped onto the device pin bus. It drives every input combination onto the device input pins and waits a programmable settle time. It then samples the device output pin, compares it against the golden function, and reports an error count, the first failing vector and a pass flag. It sits on the bench/board side of the device pins, driving the pins the device treats as inputs and reading the pin it drives.

## Interface
- N_IN, 5, number of function inputs driven (vector width); legal 2..8
- SETTLE, 4, cycles each vector is held before sampling; legal 1..255
- clk  input  1  sole clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE
- drive  output  N_IN  vector driven to device input pins; drive[0] is the inverted term
- sense  input  1  device output pin, already synchronous to clk
- busy  output  1  high from the cycle after accepted start until DONE
- done  output  1  one-cycle pulse at sweep end
- pass  output  1  registered: err_count==0 for last completed sweep
- err_count  output  N_IN+1  mismatches in last/current sweep
- first_fail  output  N_IN  vector of first mismatch; valid when err_count!=0

## Operation
- Golden: expected(v) = ~v[0] | v[1] | ... | v[N_IN-1]; only v==1 expects 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: drive=0, busy=0. start=1 -> DRIVE; vector=0, settle counter=SETTLE-1, err_count=0, first_fail=0, pass=0.
- DRIVE: drive=vector; counter decrements each cycle; at 0 -> SAMPLE.
- SAMPLE: drive still = vector; compare sense vs expected(vector). Mismatch: err_count+1 (saturating at 2^N_IN); if err_count was 0, first_fail=vector. Then if vector==all-ones -> DONE, else vector+1, counter reload, -> DRIVE.
- DONE: done=1 for exactly one cycle, pass=(err_count==0), busy=0, -> IDLE. drive returns to 0 in IDLE.
- start while busy: ignored. start in DONE cycle: ignored.
- err_count, first_fail, pass hold after DONE until next accepted start.
- Reset (any state, mid-sweep included): next cycle state=IDLE, drive=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.

## Timing
- Accepted start at cycle 0: busy=1 and drive=0 from cycle 1.
- Per vector: SETTLE DRIVE cycles + 1 SAMPLE cycle = SETTLE+1 cycles.
- sense sampled in the SAMPLE cycle of vector v, i.e. SETTLE cycles after drive first shows v.
- done pulses at cycle 1 + 2^N_IN*(SETTLE+1); defaults: cycle 161.
- err_count/first_fail update on the edge ending SAMPLE; pass updates on the edge entering DONE.
- Vector counter width N_IN+1 internally; terminal compare on low N_IN bits, no wrap beyond all-ones.

## Configuration
- PIN_TESTER_STOP_ON_FAIL_EN defined: first mismatch in SAMPLE goes directly to DONE; drive holds the failing vector through DONE, back to 0 in IDLE; err_count=1; pass=0.
- Undefined: full sweep always runs; all mismatches counted.

## Structure
- Shared package pin_tester_pkg: state enum (IDLE, DRIVE, SAMPLE, DONE), default N_IN/SETTLE constants, golden function as a function of a vector.
- One natural sub-module: pin_golden (combinational expected(v) for width N_IN), instantiated once; the rest is one FSM+counter module.

## Test plan
- Good DUT model (sense=~d[0]|d[1]|..|d[4] on drive), defaults, start at cycle 0 -> done at cycle 161, pass=1, err_count=0.
- sense stuck at 1 -> err_count=1, first_fail=5'b00001, pass=0.
- sense stuck at 0 -> err_count=31, first_fail=5'b00000, pass=0; with PIN_TESTER_STOP_ON_FAIL_EN: done at cycle 6, err_count=1, first_fail=0.
- Pulse start at cycles 3 and 40 during sweep -> ignored, single done at cycle 161; SETTLE=1 -> done at cycle 65.
- Assert rst at cycle 50 mid-sweep -> next cycle drive=0, busy=0, err_count=0; new start runs full clean sweep.
- Sense delayed 5 cycles vs drive, SETTLE=4 -> mismatches appear; SETTLE=6 -> pass=1.

Source files
------------

// File: rtl/pin_tester_pkg.sv
// rtl/pin_tester_pkg.sv - shared states, default sizing and golden function for the pin vector tester
package pin_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_N_IN   = 5;
    localparam int DEF_SETTLE = 4;
    localparam int MAX_N_IN   = 8;

    // Inverted-first-input OR over the low n bits; only v==1 yields 0.
    function automatic logic golden(input logic [MAX_N_IN-1:0] v, input int n);
        logic r;
        r = ~v[0];
        for (int i = 1; i < MAX_N_IN; i++) begin
            if (i < n) begin
                r = r | v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pin_golden.sv
// rtl/pin_golden.sv - combinational expected device output for one drive vector
module pin_golden
    import pin_tester_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
) (
    input  logic [N_IN-1:0] vec,
    output logic            expected
);

    logic [MAX_N_IN-1:0] wide;

    always_comb begin
        wide = '0;
        wide[N_IN-1:0] = vec;
    end

    assign expected = golden(wide, N_IN);

endmodule

// File: rtl/pin_vector_tester.sv
// rtl/pin_vector_tester.sv - exhaustive pin sweep FSM; PIN_TESTER_STOP_ON_FAIL_EN ends the sweep at the first mismatch
module pin_vector_tester
    import pin_tester_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] drive,
    input  logic            sense,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail
);

    localparam logic [N_IN:0] ERR_MAX     = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN:0] ONE         = {{N_IN{1'b0}}, 1'b1};
    localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE - 1);

    state_t        state;
    logic [N_IN:0] vector;
    logic [7:0]    settle_cnt;
    logic          expected;
    logic          mismatch;
    logic          last_vec;
    logic          stop_now;

    pin_golden #(.N_IN(N_IN)) u_golden (
        .vec      (vector[N_IN-1:0]),
        .expected (expected)
    );

    assign mismatch = (sense != expected);
    assign last_vec = &vector[N_IN-1:0];

`ifdef PIN_TESTER_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vector     <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        vector     <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        err_count  <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + ONE;
                        end
                        if (err_count == '0) begin
                            first_fail <= vector[N_IN-1:0];
                        end
                    end
                    if (last_vec || stop_now) begin
                        state <= ST_DONE;
                        // pass reflects the count including this final sample
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        vector     <= vector + ONE;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = (state == ST_DRIVE) || (state == ST_SAMPLE);
    assign done  = (state == ST_DONE);
    assign drive = (state == ST_IDLE) ? '0 : vector[N_IN-1:0];

endmodule

// File: tb/tb_pin_vector_tester.sv
// tb/tb_pin_vector_tester.sv - directed self-checking bench for pin_vector_tester (honours PIN_TESTER_STOP_ON_FAIL_EN)
module tb_pin_vector_tester;

`ifdef PIN_TESTER_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   sel = 0;
    int   mode = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [4:0] drive_a, drive_b, drive_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic       pass_a, pass_b, pass_c;
    logic [5:0] err_a, err_b, err_c;
    logic [4:0] ff_a, ff_b, ff_c;
    logic       sense_a, sense_b, sense_c;
    logic       start_a, start_b, start_c;
    logic [4:0] hist_a [0:4];
    logic [4:0] hist_c [0:4];

    logic [4:0] o_drive;
    logic       o_busy, o_done, o_pass;
    logic [5:0] o_err;
    logic [4:0] o_ff;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gold(input logic [4:0] v);
        return ~v[0] | (|v[4:1]);
    endfunction

    // Delay lines model a device whose output lags its inputs by 5 cycles.
    always @(posedge clk) begin
        hist_a[0] <= drive_a;
        hist_c[0] <= drive_c;
        for (int k = 1; k < 5; k++) begin
            hist_a[k] <= hist_a[k-1];
            hist_c[k] <= hist_c[k-1];
        end
    end

    always_comb begin
        sense_a = gold(drive_a);
        case (mode)
            1:       sense_a = 1'b1;
            2:       sense_a = 1'b0;
            3:       sense_a = gold(hist_a[4]);
            default: sense_a = gold(drive_a);
        endcase
    end
    assign sense_b = gold(drive_b);
    assign sense_c = gold(hist_c[4]);

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    always_comb begin
        o_drive = drive_a; o_busy = busy_a; o_done = done_a;
        o_pass = pass_a; o_err = err_a; o_ff = ff_a;
        if (sel == 1) begin
            o_drive = drive_b; o_busy = busy_b; o_done = done_b;
            o_pass = pass_b; o_err = err_b; o_ff = ff_b;
        end else if (sel == 2) begin
            o_drive = drive_c; o_busy = busy_c; o_done = done_c;
            o_pass = pass_c; o_err = err_c; o_ff = ff_c;
        end
    end

    pin_vector_tester #(.N_IN(5), .SETTLE(4)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .drive(drive_a), .sense(sense_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(ff_a)
    );

    pin_vector_tester #(.N_IN(5), .SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .start(start_b), .drive(drive_b), .sense(sense_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail(ff_b)
    );

    pin_vector_tester #(.N_IN(5), .SETTLE(6)) u_dut_s6 (
        .clk(clk), .rst(rst), .start(start_c), .drive(drive_c), .sense(sense_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .first_fail(ff_c)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Start a sweep on the selected DUT at cycle 0 and watch it up to cycle end_rel.
    task automatic run(input int inj, input int rst_at, input int end_rel,
                       output int done_at, output int n_done);
        int c0;
        int rel;
        done_at = -1;
        n_done  = 0;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        rel = cyc - c0;
        check("busy_at_cycle1", 32'(o_busy), 32'd1);
        check("drive_at_cycle1", 32'(o_drive), 32'd0);
        while (rel < end_rel) begin
            if (o_done) begin
                n_done++;
                if (done_at < 0) done_at = rel;
            end
            if (rst_at > 0 && rel == rst_at + 1) begin
                check("rst_drive", 32'(o_drive), 32'd0);
                check("rst_busy", 32'(o_busy), 32'd0);
                check("rst_err", 32'(o_err), 32'd0);
                check("rst_ff", 32'(o_ff), 32'd0);
                check("rst_pass", 32'(o_pass), 32'd0);
            end
            start = (inj != 0) && (rel == 3 || rel == 40);
            rst   = (rst_at > 0) && (rel == rst_at);
            @(negedge clk);
            rel = cyc - c0;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        int d;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_drive", 32'(o_drive), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_done", 32'(o_done), 32'd0);
        check("reset_pass", 32'(o_pass), 32'd0);
        check("reset_err", 32'(o_err), 32'd0);
        check("reset_ff", 32'(o_ff), 32'd0);
        rst = 1'b0;

        sel = 0; mode = 0;
        run(0, 0, 165, d, n);
        check("good_done_cycle", 32'(d), 32'd161);
        check("good_done_count", 32'(n), 32'd1);
        check("good_pass", 32'(o_pass), 32'd1);
        check("good_err", 32'(o_err), 32'd0);
        check("good_idle_drive", 32'(o_drive), 32'd0);

        mode = 1;
        run(0, 0, 165, d, n);
        check("stuck1_done_cycle", 32'(d), STOP ? 32'd11 : 32'd161);
        check("stuck1_err", 32'(o_err), 32'd1);
        check("stuck1_ff", 32'(o_ff), 32'd1);
        check("stuck1_pass", 32'(o_pass), 32'd0);

        mode = 2;
        run(0, 0, 165, d, n);
        check("stuck0_done_cycle", 32'(d), STOP ? 32'd6 : 32'd161);
        check("stuck0_err", 32'(o_err), STOP ? 32'd1 : 32'd31);
        check("stuck0_ff", 32'(o_ff), 32'd0);
        check("stuck0_pass", 32'(o_pass), 32'd0);

        mode = 0;
        run(1, 0, 165, d, n);
        check("ignore_start_done_cycle", 32'(d), 32'd161);
        check("ignore_start_done_count", 32'(n), 32'd1);
        check("ignore_start_pass", 32'(o_pass), 32'd1);

        mode = 2;
        run(0, 50, 60, d, n);
        check("post_rst_pass", 32'(o_pass), 32'd0);
        mode = 0;
        run(0, 0, 165, d, n);
        check("after_rst_done_cycle", 32'(d), 32'd161);
        check("after_rst_pass", 32'(o_pass), 32'd1);
        check("after_rst_err", 32'(o_err), 32'd0);

        sel = 1;
        run(0, 0, 70, d, n);
        check("settle1_done_cycle", 32'(d), 32'd65);
        check("settle1_pass", 32'(o_pass), 32'd1);

        sel = 0; mode = 3;
        run(0, 0, 165, d, n);
        check("lag_s4_done_cycle", 32'(d), STOP ? 32'd11 : 32'd161);
        check("lag_s4_err", 32'(o_err), STOP ? 32'd1 : 32'd2);
        check("lag_s4_ff", 32'(o_ff), 32'd1);
        check("lag_s4_pass", 32'(o_pass), 32'd0);

        sel = 2;
        run(0, 0, 230, d, n);
        check("lag_s6_done_cycle", 32'(d), 32'd225);
        check("lag_s6_pass", 32'(o_pass), 32'd1);
        check("lag_s6_err", 32'(o_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
